// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux
//   Interconnect stage between the single bus master and all slaves.
//   Address phase: decodes addr_i into a one-hot slave select (sel_o); an
//   address hitting no mapped slave selects the default slave (index NSlv).
//   Data phase: registers the owning slave (dsel_q) and returns its
//   rdata/resp/ready to the master; ready_o is also every slave's ready input.
//   Keeps a saturating count of completed ERROR transfers.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   addr_i, trans_i master address and transfer type (address phase)
//   sel_o           one-hot slave select, bit NSlv = default slave
//   slv_rdata_i     packed slave read data, slave k at [k*DWidth +: DWidth]
//   slv_resp_i      slave resp (0=OKAY, 1=ERROR)
//   slv_ready_i     slave ready
//   rdata_o, resp_o, ready_o  data-phase response to the master
//   err_cnt_o       saturating count of completed ERROR transfers
module ahb_decoder_mux #(
   parameter int unsigned         AWidth = 32,
   parameter int unsigned         DWidth = 32,
   parameter int unsigned         NSlv   = 4,
   parameter logic [NSlv*AWidth-1:0] SBase = '0,
   parameter logic [NSlv*AWidth-1:0] SMask = '0,
   parameter int unsigned         CWidth = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [AWidth-1:0]        addr_i,
   input  logic [1:0]               trans_i,
   output logic [NSlv:0]            sel_o,
   input  logic [(NSlv+1)*DWidth-1:0] slv_rdata_i,
   input  logic [NSlv:0]            slv_resp_i,
   input  logic [NSlv:0]            slv_ready_i,
   output logic [DWidth-1:0]        rdata_o,
   output logic                     resp_o,
   output logic                     ready_o,
   output logic [CWidth-1:0]        err_cnt_o
);

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } trans_e;

   logic [NSlv:0]       dsel_d, dsel_q;
   logic [CWidth-1:0]   err_cnt_d, err_cnt_q;
   logic                hit_found;

   // Priority decode: the first (lowest-index) hit wins, later hits ignored.
   always_comb begin
      sel_o     = '0;
      hit_found = 1'b0;
      for (int unsigned k = 0; k < NSlv; k++) begin
         if (!hit_found &&
             ((addr_i & SMask[k*AWidth +: AWidth]) == SBase[k*AWidth +: AWidth])) begin
            sel_o[k]  = 1'b1;
            hit_found = 1'b1;
         end
      end
      if (!hit_found) sel_o[NSlv] = 1'b1;
   end

   // Response mux. dsel_q is one-hot or zero, so OR-ing the selected lanes
   // never mixes two slaves; zero means no outstanding transfer.
   always_comb begin
      rdata_o = '0;
      resp_o  = 1'b0;
      ready_o = 1'b1;
      if (|dsel_q) begin
         ready_o = 1'b0;
         for (int unsigned k = 0; k < NSlv + 1; k++) begin
            if (dsel_q[k]) begin
               rdata_o = rdata_o | slv_rdata_i[k*DWidth +: DWidth];
               resp_o  = resp_o  | slv_resp_i[k];
               ready_o = ready_o | slv_ready_i[k];
            end
         end
      end
   end

   always_comb begin
      dsel_d = dsel_q;
      if (ready_o) begin
         if (trans_i == TRANS_NONSEQ || trans_i == TRANS_SEQ) dsel_d = sel_o;
         else                                                  dsel_d = '0;
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (ready_o && resp_o && (|dsel_q) && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dsel_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         dsel_q    <= dsel_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: two mapped slaves plus default slave,
// 2-bit error counter so saturation is reachable.
module tb_ahb_decoder_mux;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 2;
   localparam int unsigned CW = 2;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic            clk, rst_n;
   logic [AW-1:0]   addr;
   logic [1:0]      trans;
   logic [NS:0]     sel;
   logic [DW-1:0]   rd0, rd1, rd2;
   logic [NS:0]     resp_in, ready_in;
   logic [DW-1:0]   rdata;
   logic            resp, ready;
   logic [CW-1:0]   err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_decoder_mux #(
      .AWidth (AW),
      .DWidth (DW),
      .NSlv   (NS),
      .SBase  ({32'h0000_1000, 32'h0000_0000}),
      .SMask  ({32'hFFFF_F000, 32'hFFFF_F000}),
      .CWidth (CW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .addr_i      (addr),
      .trans_i     (trans),
      .sel_o       (sel),
      .slv_rdata_i ({rd2, rd1, rd0}),
      .slv_resp_i  (resp_in),
      .slv_ready_i (ready_in),
      .rdata_o     (rdata),
      .resp_o      (resp),
      .ready_o     (ready),
      .err_cnt_o   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; addr = '0; trans = IDLE;
      rd0 = 32'h1111_0000; rd1 = 32'h2222_0000; rd2 = 32'h3333_0000;
      resp_in = '0; ready_in = '1;
      #1;
      n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready got %0b exp 1", ready); end
      n_checks++; if (resp !== 1'b0)   begin n_fail++; $display("FAIL reset_resp got %0b exp 0", resp); end
      n_checks++; if (rdata !== '0)    begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      n_checks++; if (err_cnt !== '0)  begin n_fail++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
      n_checks++; if (dut.dsel_q !== '0) begin n_fail++; $display("FAIL reset_dsel got %b exp 000", dut.dsel_q); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL idle_ready got %0b exp 1", ready); end
   endtask

   task automatic test_decode();
      // pure decode, no transfer issued
      @(negedge clk); trans = IDLE; addr = 32'h0000_0FFF; #1;
      n_checks++; if (sel !== 3'b001) begin n_fail++; $display("FAIL dec_0fff got %b exp 001", sel); end
      addr = 32'h0000_2000; #1;
      n_checks++; if (sel !== 3'b100) begin n_fail++; $display("FAIL dec_2000 got %b exp 100", sel); end
      rd1 = 32'hDEAD_BEEF;
      @(negedge clk); addr = 32'h0000_1004; trans = NONSEQ; #1;
      n_checks++; if (sel !== 3'b010) begin n_fail++; $display("FAIL dec_1004 got %b exp 010", sel); end
      @(negedge clk); trans = IDLE; addr = '0; #1;
      n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL s1_rdata got %h exp deadbeef", rdata); end
      n_checks++; if (resp !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL s1_resp_ready got %b%b exp 01", resp, ready); end
      @(negedge clk); #1;
      n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL s1_after_idle got %h exp 0", rdata); end
   endtask

   task automatic test_wait_states();
      rd0 = 32'hAAAA_0000; rd1 = 32'hBBBB_0000;
      @(negedge clk); addr = 32'h0000_0010; trans = NONSEQ; ready_in[0] = 1'b0; #1;
      n_checks++; if (sel !== 3'b001) begin n_fail++; $display("FAIL dec_0010 got %b exp 001", sel); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); addr = 32'h0000_1008; trans = SEQ; #1;
         n_checks++; if (ready !== 1'b0 || rdata !== 32'hAAAA_0000) begin
            n_fail++; $display("FAIL wait_%0d got ready=%0b rdata=%h exp ready=0 rdata=aaaa0000", i, ready, rdata);
         end
      end
      @(negedge clk); ready_in[0] = 1'b1; #1;
      n_checks++; if (ready !== 1'b1 || rdata !== 32'hAAAA_0000) begin
         n_fail++; $display("FAIL wait_end got ready=%0b rdata=%h exp ready=1 rdata=aaaa0000", ready, rdata);
      end
      @(negedge clk); trans = IDLE; addr = '0; #1;
      n_checks++; if (rdata !== 32'hBBBB_0000) begin n_fail++; $display("FAIL seq_after_wait got %h exp bbbb0000", rdata); end
      @(negedge clk);
   endtask

   task automatic test_error();
      rd1 = 32'h1234_5678;
      @(negedge clk); addr = 32'h8000_0000; trans = NONSEQ; #1;
      n_checks++; if (sel !== 3'b100) begin n_fail++; $display("FAIL dec_unmapped got %b exp 100", sel); end
      @(negedge clk); trans = IDLE; resp_in[2] = 1'b1; ready_in[2] = 1'b0; #1;
      n_checks++; if ({resp, ready} !== 2'b10) begin n_fail++; $display("FAIL err_cycle1 got %b%b exp 10", resp, ready); end
      // second error cycle; new address accepted here
      @(negedge clk); ready_in[2] = 1'b1; addr = 32'h0000_1004; trans = NONSEQ; #1;
      n_checks++; if ({resp, ready} !== 2'b11) begin n_fail++; $display("FAIL err_cycle2 got %b%b exp 11", resp, ready); end
      n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL err_cnt_before got %0d exp 0", err_cnt); end
      @(negedge clk); trans = IDLE; resp_in[2] = 1'b0; #1;
      n_checks++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL err_cnt_after got %0d exp 1", err_cnt); end
      n_checks++; if (rdata !== 32'h1234_5678 || resp !== 1'b0) begin
         n_fail++; $display("FAIL pipelined_after_err got rdata=%h resp=%0b exp 12345678 0", rdata, resp);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      rd0 = 32'h0A0A_0A0A; rd1 = 32'h0B0B_0B0B;
      @(negedge clk); addr = 32'h0000_0000; trans = NONSEQ;
      @(negedge clk); addr = 32'h0000_1000; trans = NONSEQ; #1;
      n_checks++; if (rdata !== 32'h0A0A_0A0A) begin n_fail++; $display("FAIL b2b_first got %h exp 0a0a0a0a", rdata); end
      @(negedge clk); trans = IDLE; addr = '0; #1;
      n_checks++; if (rdata !== 32'h0B0B_0B0B) begin n_fail++; $display("FAIL b2b_second got %h exp 0b0b0b0b", rdata); end
      @(negedge clk); #1;
      n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL b2b_idle got %h exp 0", rdata); end
   endtask

   task automatic test_saturation_and_reset();
      logic [CW-1:0] exp_cnt;
      exp_cnt = 2'd1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); addr = 32'h8000_0000; trans = NONSEQ; resp_in[2] = 1'b1; ready_in[2] = 1'b1;
         @(negedge clk); trans = IDLE; #1;
         n_checks++; if (resp !== 1'b1) begin n_fail++; $display("FAIL sat_resp_%0d got %0b exp 1", i, resp); end
         @(negedge clk); #1;
         if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
         n_checks++; if (err_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt_%0d got %0d exp %0d", i, err_cnt, exp_cnt); end
      end
      resp_in[2] = 1'b0;
      @(negedge clk); addr = 32'h0000_0010; trans = NONSEQ; ready_in[0] = 1'b0;
      @(negedge clk); trans = IDLE; #1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_wait got %0b exp 0", ready); end
      #2 rst_n = 1'b0; #1;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready got %0b exp 1", ready); end
      n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL async_reset_err got %0d exp 0", err_cnt); end
      @(negedge clk); rst_n = 1'b1; ready_in[0] = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (ready !== 1'b1 || rdata !== '0) begin
         n_fail++; $display("FAIL post_reset got ready=%0b rdata=%h exp 1 0", ready, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_wait_states();
      test_error();
      test_back_to_back();
      test_saturation_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
